// File: rtl/fpu_pkg.sv
// Shared definitions for the sequential binary32 adder/subtractor.
//   - field widths and bias of the binary32 format
//   - canonical NaN / infinity patterns
//   - FSM state encoding
//   - operand class decode (NaN, signalling NaN, infinity, zero)
package fpu_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADD, NORM_RND, DONE
  } state_t;

  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic is_inf;
    logic is_zero;
  } fp_class_t;

  // exp == 0 counts as zero: denormals are flushed.
  function automatic fp_class_t classify(input logic [31:0] x);
    fp_class_t c;
    logic      e_max, m_nz;
    e_max     = &x[30:23];
    m_nz      = |x[22:0];
    c.is_nan  = e_max & m_nz;
    c.is_snan = e_max & m_nz & ~x[22];
    c.is_inf  = e_max & ~m_nz;
    c.is_zero = ~|x[30:23];
    return c;
  endfunction
endpackage

// File: rtl/fp32_lzc27.sv
// Combinational leading-zero counter over a 27-bit {mant, guard, round, sticky}
// field.
//   val : field to scan (bit 26 is the MSB)
//   lz  : number of leading zeros, 27 when val is all zero
module fp32_lzc27 (
  input  logic [26:0] val,
  output logic [4:0]  lz
);
  always_comb begin
    lz = 5'd27;
    // Scan upward so the highest set bit is the last one to write lz.
    for (int i = 0; i < 27; i++)
      if (val[i]) lz = 5'(26 - i);
  end
endmodule

// File: rtl/fp32_addsub_seq.sv
// Sequential IEEE-754 binary32 adder/subtractor, one FSM state per cycle:
// IDLE -> UNPACK -> ALIGN -> ADD -> NORM_RND -> DONE -> IDLE.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in_ready only in IDLE)
//   a, b, op_sub        : operands, 0 = a+b, 1 = a-b
//   out_valid/out_ready : result handshake, result held under back-pressure
//   result, flags       : binary32 result, {invalid, overflow, inexact}
module fp32_addsub_seq #(
  parameter int          FLUSH_DENORM = 1,
  parameter logic [31:0] QNAN         = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);
  import fpu_pkg::*;

  if (FLUSH_DENORM != 1) begin : g_flush_chk
    $error("fp32_addsub_seq: only FLUSH_DENORM=1 is supported");
  end

  state_t state_q, state_d;

  // captured operands
  logic [31:0]      a_q, b_q;
  logic             sub_q;
  // UNPACK results
  logic             sa_q, sb_q;
  logic [EXP_W-1:0] ea_q, eb_q;
  logic [MAN_W:0]   ma_q, mb_q;
  logic             spec_q, spec_inv_q;
  logic [31:0]      spec_res_q;
  // ALIGN results
  logic             s_big_q, eff_sub_q;
  logic [EXP_W-1:0] e_big_q;
  logic [26:0]      f_big_q, f_sml_q;
  // ADD result (bit 27 is the carry-out)
  logic [27:0]      sum_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (in_valid) state_d = UNPACK;
      UNPACK:   state_d = ALIGN;
      ALIGN:    state_d = ADD;
      ADD:      state_d = NORM_RND;
      NORM_RND: state_d = DONE;
      DONE:     if (out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // ---------------- UNPACK: classify and resolve specials ----------------
  fp_class_t ca, cb;
  logic      sb_eff, u_spec, u_inv;
  logic [31:0] u_res;

  assign ca     = classify(a_q);
  assign cb     = classify(b_q);
  assign sb_eff = b_q[31] ^ sub_q;

  always_comb begin
    u_spec = 1'b1;
    u_inv  = 1'b0;
    u_res  = '0;
    if (ca.is_nan || cb.is_nan) begin
      u_res = QNAN;
      u_inv = ca.is_snan | cb.is_snan;
    end else if (ca.is_inf && cb.is_inf && (a_q[31] != sb_eff)) begin
      u_res = QNAN;
      u_inv = 1'b1;
    end else if (ca.is_inf) begin
      u_res = a_q;
    end else if (cb.is_inf) begin
      u_res = {sb_eff, b_q[30:0]};
    end else if (ca.is_zero && cb.is_zero) begin
      u_res = {a_q[31] & sb_eff, 31'b0};  // only -0 + -0 keeps the sign
    end else begin
      u_spec = 1'b0;
    end
  end

  // ---------------- ALIGN: order by magnitude, shift smaller ----------------
  logic             a_big;
  logic [EXP_W-1:0] e_big, e_sml, e_dif;
  logic [MAN_W:0]   m_big, m_sml;
  logic [53:0]      sh;
  logic [26:0]      f_sml;

  always_comb begin
    a_big = {ea_q, ma_q} >= {eb_q, mb_q};
    e_big = a_big ? ea_q : eb_q;
    e_sml = a_big ? eb_q : ea_q;
    m_big = a_big ? ma_q : mb_q;
    m_sml = a_big ? mb_q : ma_q;
    e_dif = e_big - e_sml;
    // Low 27 bits of the wide shift catch everything shifted past sticky.
    sh    = {m_sml, 3'b000, 27'b0} >> e_dif;
    if (e_dif >= 8'd27) f_sml = {26'b0, |m_sml};
    else                f_sml = {sh[53:28], sh[27] | (|sh[26:0])};
  end

  // ---------------- ADD ----------------
  logic [27:0] sum_d;
  assign sum_d = eff_sub_q ? ({1'b0, f_big_q} - {1'b0, f_sml_q})
                           : ({1'b0, f_big_q} + {1'b0, f_sml_q});

  // ---------------- NORM_RND ----------------
  logic [4:0]        lz;
  logic [26:0]       m_n;
  logic signed [9:0] e_n, e_r;
  logic              rnd_up, inx;
  logic [24:0]       m_r;
  logic [31:0]       res_d;
  logic [2:0]        flg_d;

  fp32_lzc27 u_lzc (.val(sum_q[26:0]), .lz(lz));

  always_comb begin
    if (sum_q[27]) begin
      m_n = {sum_q[27:2], |sum_q[1:0]};
      e_n = $signed({2'b00, e_big_q}) + 10'sd1;
    end else begin
      m_n = sum_q[26:0] << lz;
      e_n = $signed({2'b00, e_big_q}) - $signed({5'b0, lz});
    end
    inx    = |m_n[2:0];
    rnd_up = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);  // nearest, ties to even
    m_r    = {1'b0, m_n[26:3]} + {24'b0, rnd_up};
    e_r    = m_r[24] ? e_n + 10'sd1 : e_n;
    res_d  = {s_big_q, e_r[7:0], m_r[24] ? m_r[23:1] : m_r[22:0]};
    flg_d  = {2'b00, inx};
    if (spec_q) begin
      res_d = spec_res_q;
      flg_d = {spec_inv_q, 2'b00};
    end else if (sum_q == '0) begin
      res_d = '0;                       // exact cancellation is +0
      flg_d = '0;
    end else if (e_n <= 10'sd0) begin
      res_d = {s_big_q, 31'b0};         // flushed: a nonzero value was lost
      flg_d = 3'b001;
    end else if (e_r >= 10'sd255) begin
      res_d = s_big_q ? NEG_INF : POS_INF;
      flg_d = 3'b011;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; sub_q <= 1'b0;
      sa_q <= 1'b0; sb_q <= 1'b0; ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
      spec_q <= 1'b0; spec_inv_q <= 1'b0; spec_res_q <= '0;
      s_big_q <= 1'b0; eff_sub_q <= 1'b0; e_big_q <= '0; f_big_q <= '0; f_sml_q <= '0;
      sum_q <= '0;
      result <= '0; flags <= '0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        a_q <= a; b_q <= b; sub_q <= op_sub;
      end
      if (state_q == UNPACK) begin
        sa_q <= a_q[31];
        sb_q <= sb_eff;
        ea_q <= ca.is_zero ? '0 : a_q[30:23];
        eb_q <= cb.is_zero ? '0 : b_q[30:23];
        ma_q <= ca.is_zero ? '0 : {1'b1, a_q[22:0]};
        mb_q <= cb.is_zero ? '0 : {1'b1, b_q[22:0]};
        spec_q <= u_spec; spec_inv_q <= u_inv; spec_res_q <= u_res;
      end
      if (state_q == ALIGN) begin
        s_big_q   <= a_big ? sa_q : sb_q;
        eff_sub_q <= sa_q ^ sb_q;
        e_big_q   <= e_big;
        f_big_q   <= {m_big, 3'b000};
        f_sml_q   <= f_sml;
      end
      if (state_q == ADD)      sum_q <= sum_d;
      if (state_q == NORM_RND) begin
        result <= res_d;
        flags  <= flg_d;
      end
    end
  end
endmodule

// File: tb/tb_fp32_addsub_seq.sv
// Self-checking bench for fp32_addsub_seq: exact big-integer reference model,
// one monitor process checking every output beat, directed + random stimulus.
module tb_fp32_addsub_seq;
  logic        clk, rst_n, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [2:0]  flags;

  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0, n_acc = 0, n_out = 0, issued = 0, aborted = 0;
  bit seen_valid = 0, hold_mode = 0, hold_rel = 0;
  logic [34:0] exp_q[$];

  fp32_addsub_seq #(.FLUSH_DENORM(1), .QNAN(32'h7FC00000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: operands become exact integers in units of 2^-149, are summed
  // exactly, then rounded once to binary32. Returns {result, flags}.
  function automatic logic [34:0] ref_add(input logic [31:0] x, y, input logic sub);
    logic sx, sy, sr, nx, ny, snan, ix, iy, zx, zy, rnd, inx;
    logic [299:0] mx, my, mag, rem, half, q;
    int p, e, sh;
    sx = x[31]; sy = y[31] ^ sub;
    nx = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    ny = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    snan = (nx && !x[22]) || (ny && !y[22]);
    ix = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    iy = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    zx = (x[30:23] == 0); zy = (y[30:23] == 0);
    if (nx || ny) return {32'h7FC00000, snan, 2'b00};
    if (ix && iy && sx != sy) return {32'h7FC00000, 3'b100};
    if (ix) return {x, 3'b000};
    if (iy) return {sy, y[30:0], 3'b000};
    if (zx && zy) return {sx & sy, 31'b0, 3'b000};
    mx = zx ? '0 : ({276'b0, 1'b1, x[22:0]} << (x[30:23] - 1));
    my = zy ? '0 : ({276'b0, 1'b1, y[22:0]} << (y[30:23] - 1));
    if (sx == sy)     begin mag = mx + my; sr = sx; end
    else if (mx >= my) begin mag = mx - my; sr = sx; end
    else               begin mag = my - mx; sr = sy; end
    if (mag == 0) return 35'd0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;                      // biased exponent of the exact sum
    if (e <= 0) return {sr, 31'b0, 3'b001};
    sh   = p - 23;
    q    = mag >> sh;
    rem  = mag & ((300'd1 << sh) - 300'd1);
    half = (sh > 0) ? (300'd1 << (sh - 1)) : '0;
    rnd  = (sh > 0) && ((rem > half) || (rem == half && q[0]));
    inx  = (rem != 0);
    q    = q + rnd;
    if (q[24]) begin q = q >> 1; e = e + 1; end
    if (e >= 255) return {sr, 8'hFF, 23'b0, 3'b011};
    return {sr, e[7:0], q[22:0], 2'b00, inx};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: runs on the falling edge, sees what the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      seen_valid = 0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(a, b, op_sub));
        acc_cyc = cyc + 1;
        n_acc++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out", {result, flags}, 64'hDEAD);
        else check("result_flags", {result, flags}, exp_q[0]);
        // first beat must fall in the 5th cycle after the accept edge
        if (!seen_valid) check("latency", cyc - acc_cyc, 4);
        check("busy_in_ready", in_ready, 0);
        seen_valid = 1;
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          seen_valid = 0;
          n_out++;
        end
      end
    end
  end

  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk); #1;
      out_ready = hold_mode ? hold_rel : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub, input bit hold);
    int n = 0;
    a = ia; b = ib; op_sub = isub; in_valid = 1;
    while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout got=in_ready 0 want=1");
      in_valid = 0;
      return;
    end
    @(posedge clk); #1;
    issued++;
    if (!hold) begin in_valid = 0; a = $urandom; b = $urandom; op_sub = 1'($urandom_range(0, 1)); end
  endtask

  task automatic wait_out();
    int n0 = n_out, k = 0;
    while (n_out == n0 && k < 300) begin @(posedge clk); #1; k++; end
    if (n_out == n0) begin
      total++; bad++;
      $display("FAIL out_timeout got=no transfer want=transfer");
    end
  endtask

  function automatic logic [31:0] rnd_op(input int base);
    int k = $urandom_range(0, 19);
    int e;
    logic [31:0] r = $urandom;
    case (k)
      0: r = {r[31], 8'hFF, 23'b0};
      1: r = {r[31], 8'hFF, 1'b1, r[21:0]};
      2: r = {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
      3: r = {r[31], 31'b0};
      4: r = {r[31], 8'h00, r[22:0]};
      5: r = {r[31], 8'hFE, r[22:0]};
      default: begin
        e = base + int'($urandom_range(0, 60)) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        r[30:23] = e[7:0];
      end
    endcase
    return r;
  endfunction

  logic [31:0] va[12] = '{32'h3F800000, 32'h40080000, 32'h41A00000, 32'h40490FDB,
                          32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h7F7FFFFF,
                          32'h7FC00000, 32'h80000000, 32'h7F800001, 32'hFF800000};
  logic [31:0] vb[12] = '{32'h41A00000, 32'h40080000, 32'h3F800000, 32'h40490FDB,
                          32'h33800000, 32'h33800001, 32'h7F800000, 32'h7F7FFFFF,
                          32'h3F800000, 32'h80000000, 32'h00000000, 32'h3F800000};
  logic        vs[12] = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0};
  logic [34:0] vx[12] = '{{32'h41A80000, 3'b000}, {32'h40880000, 3'b000},
                          {32'h41980000, 3'b000}, {32'h00000000, 3'b000},
                          {32'h3F800000, 3'b001}, {32'h3F800001, 3'b001},
                          {32'h7FC00000, 3'b100}, {32'h7F800000, 3'b011},
                          {32'h7FC00000, 3'b000}, {32'h80000000, 3'b000},
                          {32'h7FC00000, 3'b100}, {32'hFF800000, 3'b000}};

  initial begin
    int k, base;
    logic [31:0] ra, rb;
    rst_n = 0; in_valid = 0; a = 0; b = 0; op_sub = 0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // pin the model to hand-computed vectors, then run them through the DUT
    for (int i = 0; i < 12; i++) check("model_pin", ref_add(va[i], vb[i], vs[i]), vx[i]);
    for (int i = 0; i < 12; i++) do_op(va[i], vb[i], vs[i], 0);
    wait_out();

    // back-pressure for 10 cycles with in_valid held high across the op
    hold_mode = 1; hold_rel = 0;
    @(posedge clk); #1;
    do_op(32'h3F800000, 32'h41A00000, 1'b0, 1);
    a = $urandom; b = $urandom;
    k = 0;
    while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
    check("hold_reached", out_valid, 1);
    repeat (10) begin
      @(posedge clk); #1;
      check("hold_stable", {result, flags}, {32'h41A80000, 3'b000});
      check("hold_in_ready", in_ready, 0);
    end
    hold_rel = 1;
    wait_out();
    in_valid = 0; hold_mode = 0; hold_rel = 0;
    @(posedge clk); #1;

    // reset while the op sits in ALIGN
    do_op(32'h40490FDB, 32'h3F800000, 1'b0, 0);
    @(posedge clk); #1;
    rst_n = 0; #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_flags", flags, 0);
    check("midrst_in_ready", in_ready, 1);
    aborted++;
    @(negedge clk); #2; rst_n = 1;
    @(posedge clk); #1;
    do_op(32'h41A00000, 32'h3F800000, 1'b1, 0);
    wait_out();

    // random traffic with random back-pressure
    for (int i = 0; i < 150; i++) begin
      base = $urandom_range(1, 254);
      if ($urandom_range(0, 5) == 0) base = $urandom_range(1, 12);
      ra = rnd_op(base);
      rb = rnd_op(base);
      if ($urandom_range(0, 4) == 0) rb = ra ^ 32'($urandom_range(0, 15));
      do_op(ra, rb, 1'($urandom_range(0, 1)), 0);
    end
    wait_out();
    repeat (3) @(posedge clk);
    #1;
    check("accept_count", n_acc, issued);
    check("output_count", n_out, issued - aborted);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
